// File: rtl/unidade_entrada_saida.sv
// I/O handshake unit. It answers the control unit's inp/out strobes. An out
// latches the datapath value into the display register. An inp stalls the
// processor until the confirm button is released and then pressed, each level
// held stable for DEBOUNCE cycles. The switch value is then returned for
// write-back.
module unidade_entrada_saida #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CHAVES_W = 16,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              inp,
    input  logic              out,
    input  logic [DATA_W-1:0] dadoSaida,
    input  logic [CHAVES_W-1:0] chaves,
    input  logic              botao,
    output logic              stall,
    output logic [DATA_W-1:0] dadoEntrada,
    output logic              entradaValida,
    output logic [DATA_W-1:0] regSaida,
    output logic              saidaAtualizada,
    output logic              aguardando
);

    // Counter holds 0..DEBOUNCE. The transition fires on the DEBOUNCE-th
    // qualifying cycle, so the counter normally tops out at DEBOUNCE-1.
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (CHAVES_W > DATA_W) begin : g_bad_chaves_w
            $error("CHAVES_W must not exceed DATA_W");
        end
        if (DEBOUNCE < 1) begin : g_bad_debounce
            $error("DEBOUNCE must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        StOcioso        = 2'd0,
        StEsperaSoltar  = 2'd1,
        StEsperaApertar = 2'd2,
        StCaptura       = 2'd3
    } estado_e;

    estado_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              b_meta_q, b_sync_q;
    logic [DATA_W-1:0] dado_entrada_q;
    logic [DATA_W-1:0] reg_saida_q;
    logic              saida_atualizada_q;
    logic              capture;
    logic              update;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            b_meta_q <= 1'b0;
            b_sync_q <= 1'b0;
        end else begin
            b_meta_q <= botao;
            b_sync_q <= b_meta_q;
        end
    end

    // State and debounce counter registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StOcioso;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: release qualification, press qualification, then capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        update  = 1'b0;
        unique case (state_q)
            StOcioso: begin
                cnt_d = '0;
                // inp has priority if the decoder ever raises both strobes.
                if (inp) begin
                    state_d = StEsperaSoltar;
                end else if (out) begin
                    update = 1'b1;
                end
            end
            StEsperaSoltar: begin
                // A press held over from an earlier inp must be released first.
                if (b_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = StEsperaApertar;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StEsperaApertar: begin
                if (!b_sync_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    capture = 1'b1;
                    state_d = StCaptura;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            StCaptura: begin
                cnt_d   = '0;
                state_d = StOcioso;
            end
            default: begin
                cnt_d   = '0;
                state_d = StOcioso;
            end
        endcase
    end

    // Captured switch value, zero-extended. It holds until the next capture.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            dado_entrada_q <= '0;
        end else if (capture) begin
            dado_entrada_q <= DATA_W'(chaves);
        end
    end

    // Display register and its one-cycle update pulse.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            reg_saida_q        <= '0;
            saida_atualizada_q <= 1'b0;
        end else begin
            saida_atualizada_q <= update;
            if (update) begin
                reg_saida_q <= dadoSaida;
            end
        end
    end

    // Outputs. Gating with resetN drops stall at once even while inp is held.
    always_comb begin
        stall = resetN && ((state_q == StOcioso && inp) ||
                           state_q == StEsperaSoltar ||
                           state_q == StEsperaApertar);
        aguardando      = resetN && (state_q == StEsperaSoltar ||
                                     state_q == StEsperaApertar);
        entradaValida   = resetN && (state_q == StCaptura);
        dadoEntrada     = dado_entrada_q;
        regSaida        = reg_saida_q;
        saidaAtualizada = saida_atualizada_q;
    end

endmodule

// File: tb/tb_unidade_entrada_saida.sv
// Directed bench for unidade_entrada_saida with DEBOUNCE=4.
module tb_unidade_entrada_saida;

    logic        clock = 1'b0;
    logic        resetN;
    logic        inp;
    logic        out;
    logic [31:0] dadoSaida;
    logic [15:0] chaves;
    logic        botao;
    logic        stall;
    logic [31:0] dadoEntrada;
    logic        entradaValida;
    logic [31:0] regSaida;
    logic        saidaAtualizada;
    logic        aguardando;

    int tests_run = 0;
    int tests_failed = 0;

    unidade_entrada_saida #(
        .DATA_W  (32),
        .CHAVES_W(16),
        .DEBOUNCE(4)
    ) dut (
        .clock          (clock),
        .resetN         (resetN),
        .inp            (inp),
        .out            (out),
        .dadoSaida      (dadoSaida),
        .chaves         (chaves),
        .botao          (botao),
        .stall          (stall),
        .dadoEntrada    (dadoEntrada),
        .entradaValida  (entradaValida),
        .regSaida       (regSaida),
        .saidaAtualizada(saidaAtualizada),
        .aguardando     (aguardando)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN    = 1'b0;
        inp       = 1'b0;
        out       = 1'b0;
        dadoSaida = 32'h0;
        chaves    = 16'h0;
        botao     = 1'b0;
        tick();
        tick();
        check_val("rst_stall", {31'b0, stall}, 32'd0);
        check_val("rst_valid", {31'b0, entradaValida}, 32'd0);
        check_val("rst_aguard", {31'b0, aguardando}, 32'd0);
        check_val("rst_upd", {31'b0, saidaAtualizada}, 32'd0);
        check_val("rst_regsaida", regSaida, 32'h0);
        check_val("rst_dadoentrada", dadoEntrada, 32'h0);
        resetN = 1'b1;
        tick();

        // Output write: one-cycle out strobe.
        out       = 1'b1;
        dadoSaida = 32'h0000_002A;
        #1;
        check_val("out_stall0", {31'b0, stall}, 32'd0);
        tick();
        out = 1'b0;
        check_val("out_reg", regSaida, 32'h0000_002A);
        check_val("out_upd1", {31'b0, saidaAtualizada}, 32'd1);
        check_val("out_stall1", {31'b0, stall}, 32'd0);
        tick();
        check_val("out_upd0", {31'b0, saidaAtualizada}, 32'd0);
        check_val("out_reg_hold", regSaida, 32'h0000_002A);

        // Clean input: released button qualifies in 4 cycles after entry.
        chaves = 16'h00FF;
        inp    = 1'b1;
        #1;
        check_val("in_stall_same", {31'b0, stall}, 32'd1);
        check_val("in_aguard_ocioso", {31'b0, aguardando}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("in_rel_stall%0d", i), {31'b0, stall}, 32'd1);
            check_val($sformatf("in_rel_aguard%0d", i), {31'b0, aguardando}, 32'd1);
        end
        botao = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("in_press_nov%0d", i), {31'b0, entradaValida}, 32'd0);
            check_val($sformatf("in_press_stall%0d", i), {31'b0, stall}, 32'd1);
        end
        tick();
        check_val("in_valid", {31'b0, entradaValida}, 32'd1);
        check_val("in_valid_stall", {31'b0, stall}, 32'd0);
        check_val("in_dado", dadoEntrada, 32'h0000_00FF);
        check_val("in_valid_aguard", {31'b0, aguardando}, 32'd0);

        // Back-to-back inp with the button still held.
        chaves = 16'h1234;
        tick();
        check_val("b2b_valid_once", {31'b0, entradaValida}, 32'd0);
        check_val("b2b_stall", {31'b0, stall}, 32'd1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_val($sformatf("b2b_held_stall%0d", i), {31'b0, stall}, 32'd1);
            check_val($sformatf("b2b_held_nov%0d", i), {31'b0, entradaValida}, 32'd0);
        end
        botao = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check_val($sformatf("b2b_rel_stall%0d", i), {31'b0, stall}, 32'd1);
        end

        // Bounce: high 3, low 1, high thereafter. Capture on the 10th edge.
        for (int i = 1; i <= 10; i++) begin
            if (i <= 3) botao = 1'b1;
            else if (i == 4) botao = 1'b0;
            else botao = 1'b1;
            tick();
            if (i < 10) begin
                check_val($sformatf("bnc_nov%0d", i), {31'b0, entradaValida}, 32'd0);
                check_val($sformatf("bnc_stall%0d", i), {31'b0, stall}, 32'd1);
            end
        end
        check_val("bnc_valid", {31'b0, entradaValida}, 32'd1);
        check_val("bnc_dado", dadoEntrada, 32'h0000_1234);
        inp = 1'b0;
        tick();
        check_val("bnc_single", {31'b0, entradaValida}, 32'd0);
        check_val("bnc_idle_stall", {31'b0, stall}, 32'd0);

        // Wait with out asserted, then reset while waiting for the press.
        botao = 1'b0;
        inp   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            out       = (i == 3 || i == 4);
            dadoSaida = 32'hDEAD_BEEF;
            tick();
        end
        out = 1'b0;
        check_val("wait_reg_hold", regSaida, 32'h0000_002A);
        check_val("wait_upd0", {31'b0, saidaAtualizada}, 32'd0);
        check_val("wait_aguard", {31'b0, aguardando}, 32'd1);
        check_val("wait_stall", {31'b0, stall}, 32'd1);
        botao = 1'b1;
        tick();
        tick();
        resetN = 1'b0;
        #1;
        check_val("mid_rst_stall", {31'b0, stall}, 32'd0);
        check_val("mid_rst_valid", {31'b0, entradaValida}, 32'd0);
        check_val("mid_rst_aguard", {31'b0, aguardando}, 32'd0);
        check_val("mid_rst_reg", regSaida, 32'h0);
        check_val("mid_rst_dado", dadoEntrada, 32'h0);
        tick();
        inp    = 1'b0;
        botao  = 1'b0;
        resetN = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            check_val($sformatf("post_rst_nov%0d", i), {31'b0, entradaValida}, 32'd0);
            check_val($sformatf("post_rst_stall%0d", i), {31'b0, stall}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
